// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing the execute-stage ALU between two requesters
module alu_arbiter #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32,
  parameter int TAGW   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          req_valid_i,
  output logic [1:0]          req_ready_o,
  input  logic [2*AWIDTH-1:0] req_pc_i,
  input  logic [2*DWIDTH-1:0] req_rs1_i,
  input  logic [2*DWIDTH-1:0] req_rs2_i,
  input  logic [5:0]          req_funct3_i,
  input  logic [13:0]         req_funct7_i,
  input  logic [2*TAGW-1:0]   req_tag_i,
  output logic [AWIDTH-1:0]   alu_pc_o,
  output logic [DWIDTH-1:0]   alu_rs1_o,
  output logic [DWIDTH-1:0]   alu_rs2_o,
  output logic [2:0]          alu_funct3_o,
  output logic [6:0]          alu_funct7_o,
  input  logic [DWIDTH-1:0]   alu_res_i,
  input  logic                alu_brtaken_i,
  output logic [1:0]          resp_valid_o,
  input  logic [1:0]          resp_ready_i,
  output logic [DWIDTH-1:0]   resp_res_o,
  output logic                resp_brtaken_o,
  output logic [TAGW-1:0]     resp_tag_o,
  output logic                busy_o
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state, state_nxt;
  logic            owner;
  logic            ptr;
  logic [TAGW-1:0] tag_q;
  logic [1:0]      grant;
  logic            resp_done;
  logic            fire;
  logic            grant_idx;

  // Pointer only matters under contention; a lone requester always wins.
  always_comb begin
    grant = 2'b00;
    case (req_valid_i)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  assign resp_done = (state == RESP) && resp_ready_i[owner];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    req_ready_o = 2'b00;
    case (state)
      IDLE: begin
        req_ready_o = grant;
        if (|grant) state_nxt = EXEC;
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        if (resp_done) begin
          req_ready_o = grant;
          state_nxt   = (|grant) ? EXEC : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign fire      = |req_ready_o;
  assign grant_idx = req_ready_o[1];
  assign busy_o    = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_pc_o       <= '0;
      alu_rs1_o      <= '0;
      alu_rs2_o      <= '0;
      alu_funct3_o   <= '0;
      alu_funct7_o   <= '0;
      tag_q          <= '0;
      owner          <= 1'b0;
      ptr            <= 1'b0;
      resp_valid_o   <= 2'b00;
      resp_res_o     <= '0;
      resp_brtaken_o <= 1'b0;
      resp_tag_o     <= '0;
    end else begin
      if (fire) begin
        alu_pc_o     <= grant_idx ? req_pc_i[AWIDTH +: AWIDTH]  : req_pc_i[0 +: AWIDTH];
        alu_rs1_o    <= grant_idx ? req_rs1_i[DWIDTH +: DWIDTH] : req_rs1_i[0 +: DWIDTH];
        alu_rs2_o    <= grant_idx ? req_rs2_i[DWIDTH +: DWIDTH] : req_rs2_i[0 +: DWIDTH];
        alu_funct3_o <= grant_idx ? req_funct3_i[5:3]           : req_funct3_i[2:0];
        alu_funct7_o <= grant_idx ? req_funct7_i[13:7]          : req_funct7_i[6:0];
        tag_q        <= grant_idx ? req_tag_i[TAGW +: TAGW]     : req_tag_i[0 +: TAGW];
        owner        <= grant_idx;
        ptr          <= ~grant_idx;
      end
      // The ALU is purely combinational, so its result is ready one cycle after the operands.
      if (state == EXEC) begin
        resp_res_o     <= alu_res_i;
        resp_brtaken_o <= alu_brtaken_i;
        resp_tag_o     <= tag_q;
        resp_valid_o   <= owner ? 2'b10 : 2'b01;
      end else if (resp_done) begin
        resp_valid_o   <= 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter with a stand-in ALU
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid_i, req_ready_o;
  logic [63:0] req_pc_i, req_rs1_i, req_rs2_i;
  logic [5:0]  req_funct3_i;
  logic [13:0] req_funct7_i;
  logic [7:0]  req_tag_i;
  logic [31:0] alu_pc_o, alu_rs1_o, alu_rs2_o;
  logic [2:0]  alu_funct3_o;
  logic [6:0]  alu_funct7_o;
  logic [31:0] alu_res_i;
  logic        alu_brtaken_i;
  logic [1:0]  resp_valid_o, resp_ready_i;
  logic [31:0] resp_res_o;
  logic        resp_brtaken_o;
  logic [3:0]  resp_tag_o;
  logic        busy_o;

  int n_checks = 0;
  int n_pass   = 0;
  int resp_count = 0;

  typedef struct {
    logic [1:0]  who;
    logic [31:0] res;
    logic        br;
    logic [3:0]  tag;
  } sb_t;
  sb_t sb[$];

  alu_arbiter #(.DWIDTH(32), .AWIDTH(32), .TAGW(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_pc_i(req_pc_i), .req_rs1_i(req_rs1_i), .req_rs2_i(req_rs2_i),
    .req_funct3_i(req_funct3_i), .req_funct7_i(req_funct7_i), .req_tag_i(req_tag_i),
    .alu_pc_o(alu_pc_o), .alu_rs1_o(alu_rs1_o), .alu_rs2_o(alu_rs2_o),
    .alu_funct3_o(alu_funct3_o), .alu_funct7_o(alu_funct7_o),
    .alu_res_i(alu_res_i), .alu_brtaken_i(alu_brtaken_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_res_o(resp_res_o), .resp_brtaken_o(resp_brtaken_o), .resp_tag_o(resp_tag_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // Stand-in ALU: funct7 0 = add, 0x20 = sub, anything else = branch (target, rs1==rs2).
  function automatic logic [32:0] alu_model(input logic [31:0] pc, input logic [31:0] rs1,
                                            input logic [31:0] rs2, input logic [6:0] f7);
    if (f7 == 7'h00)      alu_model = {1'b0, rs1 + rs2};
    else if (f7 == 7'h20) alu_model = {1'b0, rs1 - rs2};
    else                  alu_model = {rs1 == rs2, pc + rs2};
  endfunction

  assign {alu_brtaken_i, alu_res_i} = alu_model(alu_pc_o, alu_rs1_o, alu_rs2_o, alu_funct7_o);

  // Scoreboard: push at request handshake, pop and compare at response handshake.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
    end else begin
      if (|(resp_valid_o & resp_ready_i)) begin
        resp_count++;
        n_checks++;
        if (sb.size() == 0) begin
          $display("FAIL sb_underflow: got response valid=%b, expected none", resp_valid_o);
        end else begin
          sb_t e;
          e = sb.pop_front();
          if (resp_valid_o === e.who && resp_res_o === e.res &&
              resp_brtaken_o === e.br && resp_tag_o === e.tag)
            n_pass++;
          else
            $display("FAIL sb_resp: got valid=%b res=%h br=%b tag=%h, expected valid=%b res=%h br=%b tag=%h",
                     resp_valid_o, resp_res_o, resp_brtaken_o, resp_tag_o, e.who, e.res, e.br, e.tag);
        end
      end
      if (|(req_valid_i & req_ready_o)) begin
        sb_t e;
        int g;
        logic [32:0] m;
        g = req_ready_o[1] ? 1 : 0;
        m = alu_model(req_pc_i[g*32 +: 32], req_rs1_i[g*32 +: 32], req_rs2_i[g*32 +: 32],
                      req_funct7_i[g*7 +: 7]);
        e.who = req_ready_o;
        e.res = m[31:0];
        e.br  = m[32];
        e.tag = req_tag_i[g*4 +: 4];
        sb.push_back(e);
      end
    end
  end

  task automatic drive_req(input int n, input logic [31:0] pc, input logic [31:0] rs1,
                           input logic [31:0] rs2, input logic [6:0] f7, input logic [3:0] tag);
    req_pc_i[n*32 +: 32]   = pc;
    req_rs1_i[n*32 +: 32]  = rs1;
    req_rs2_i[n*32 +: 32]  = rs2;
    req_funct3_i[n*3 +: 3] = 3'd0;
    req_funct7_i[n*7 +: 7] = f7;
    req_tag_i[n*4 +: 4]    = tag;
    req_valid_i[n]         = 1'b1;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!busy_o) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic wait_resp(output bit ok);
    ok = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (resp_valid_o != 2'b00) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_checks++;
    if (busy_o === 1'b0 && resp_valid_o === 2'b00 && req_ready_o === 2'b00 &&
        alu_rs1_o === 32'd0 && alu_pc_o === 32'd0 && resp_res_o === 32'd0 && resp_tag_o === 4'd0)
      n_pass++;
    else
      $display("FAIL reset_state: got busy=%b rv=%b rdy=%b rs1=%h pc=%h res=%h tag=%h, expected all 0",
               busy_o, resp_valid_o, req_ready_o, alu_rs1_o, alu_pc_o, resp_res_o, resp_tag_o);
  endtask

  task automatic test_contention;
    int grants = 0, cyc = 0, last = 0, base;
    logic [1:0] exp_g = 2'b01;
    bit ok;
    base = resp_count;
    @(posedge clk); #1;
    resp_ready_i = 2'b11;
    drive_req(0, 32'h0, 32'd10, 32'd1, 7'h00, 4'd1);
    drive_req(1, 32'h0, 32'd20, 32'd3, 7'h20, 4'd2);
    while (grants < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (req_ready_o != 2'b00) begin
        n_checks++;
        if (req_ready_o === exp_g) n_pass++;
        else $display("FAIL contention_grant: got %b, expected %b", req_ready_o, exp_g);
        if (grants > 0) begin
          n_checks++;
          if (cyc - last == 2) n_pass++;
          else $display("FAIL contention_spacing: got %0d cycles, expected 2", cyc - last);
        end
        last = cyc;
        grants++;
        exp_g = ~exp_g;
        if (grants == 4) begin
          @(posedge clk); #1;
          req_valid_i = 2'b00;
        end
      end
    end
    if (grants != 4) begin
      req_valid_i = 2'b00;
      n_checks++;
      $display("FAIL contention_count: got %0d grants, expected 4", grants);
    end
    wait_idle(ok);
    n_checks++;
    if (ok && resp_count - base == 4) n_pass++;
    else $display("FAIL contention_resps: got %0d responses idle=%0d, expected 4", resp_count - base, ok);
  endtask

  task automatic test_single_add;
    @(posedge clk); #1;
    resp_ready_i = 2'b11;
    drive_req(0, 32'h0, 32'd5, 32'd7, 7'h00, 4'd3);
    @(negedge clk);
    n_checks++;
    if (req_ready_o === 2'b01) n_pass++;
    else $display("FAIL add_ready: got %b, expected 01", req_ready_o);
    @(posedge clk); #1;
    req_valid_i = 2'b00;
    @(negedge clk);
    n_checks++;
    if (alu_rs1_o === 32'd5 && resp_valid_o === 2'b00 && busy_o === 1'b1) n_pass++;
    else $display("FAIL add_exec: got rs1=%h rv=%b busy=%b, expected 5 00 1", alu_rs1_o, resp_valid_o, busy_o);
    @(negedge clk);
    n_checks++;
    if (resp_valid_o === 2'b01 && resp_res_o === 32'd12 && resp_tag_o === 4'd3) n_pass++;
    else $display("FAIL add_resp: got rv=%b res=%h tag=%h, expected 01 c 3", resp_valid_o, resp_res_o, resp_tag_o);
    @(negedge clk);
    n_checks++;
    if (resp_valid_o === 2'b00 && busy_o === 1'b0) n_pass++;
    else $display("FAIL add_done: got rv=%b busy=%b, expected 00 0", resp_valid_o, busy_o);
  endtask

  task automatic test_backpressure;
    bit ok;
    @(posedge clk); #1;
    resp_ready_i = 2'b01;
    drive_req(1, 32'h100, 32'h20, 32'h20, 7'h63, 4'd5);
    @(negedge clk);
    n_checks++;
    if (req_ready_o === 2'b10) n_pass++;
    else $display("FAIL bp_grant: got %b, expected 10", req_ready_o);
    @(posedge clk); #1;
    req_valid_i = 2'b00;
    drive_req(0, 32'h0, 32'd1, 32'd2, 7'h00, 4'd6);
    wait_resp(ok);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL bp_timeout: got no response, expected one");
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (resp_valid_o === 2'b10 && resp_res_o === 32'h120 && resp_brtaken_o === 1'b1 &&
          resp_tag_o === 4'd5 && req_ready_o === 2'b00) n_pass++;
      else $display("FAIL bp_hold%0d: got rv=%b res=%h br=%b tag=%h rdy=%b, expected 10 120 1 5 00",
                    k, resp_valid_o, resp_res_o, resp_brtaken_o, resp_tag_o, req_ready_o);
      @(negedge clk);
    end
    @(posedge clk); #1;
    resp_ready_i = 2'b11;
    @(negedge clk);
    n_checks++;
    if (req_ready_o === 2'b01) n_pass++;
    else $display("FAIL bp_b2b_grant: got %b, expected 01", req_ready_o);
    @(posedge clk); #1;
    req_valid_i = 2'b00;
    wait_idle(ok);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL bp_idle: got busy=%b, expected 0", busy_o);
  endtask

  task automatic test_wrong_owner;
    bit ok;
    @(posedge clk); #1;
    resp_ready_i = 2'b10;
    drive_req(0, 32'h0, 32'd40, 32'd2, 7'h20, 4'd7);
    @(posedge clk); #1;
    req_valid_i = 2'b00;
    wait_resp(ok);
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (ok && resp_valid_o === 2'b01 && resp_res_o === 32'd38) n_pass++;
      else $display("FAIL wrong_owner%0d: got rv=%b res=%h, expected 01 26", k, resp_valid_o, resp_res_o);
      @(negedge clk);
    end
    @(posedge clk); #1;
    resp_ready_i = 2'b01;
    wait_idle(ok);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL wrong_owner_idle: got busy=%b, expected 0", busy_o);
    resp_ready_i = 2'b11;
  endtask

  task automatic test_reset_mid_exec;
    int base;
    bit ok;
    base = resp_count;
    @(posedge clk); #1;
    drive_req(0, 32'h0, 32'd9, 32'd9, 7'h00, 4'd8);
    @(posedge clk); #1;
    req_valid_i = 2'b00;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (resp_valid_o === 2'b00 && alu_rs1_o === 32'd0 && busy_o === 1'b0 && resp_res_o === 32'd0)
      n_pass++;
    else $display("FAIL rst_async: got rv=%b rs1=%h busy=%b res=%h, expected all 0",
                  resp_valid_o, alu_rs1_o, busy_o, resp_res_o);
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    drive_req(0, 32'h0, 32'd3, 32'd4, 7'h00, 4'd10);
    drive_req(1, 32'h0, 32'd8, 32'd1, 7'h00, 4'd11);
    @(negedge clk);
    n_checks++;
    if (req_ready_o === 2'b01) n_pass++;
    else $display("FAIL rst_ptr: got %b, expected 01", req_ready_o);
    @(posedge clk); #1;
    req_valid_i = 2'b00;
    wait_idle(ok);
    n_checks++;
    if (ok && resp_count - base == 1) n_pass++;
    else $display("FAIL rst_drop: got %0d responses, expected 1", resp_count - base);
  endtask

  task automatic test_operand_stability;
    bit ok;
    @(posedge clk); #1;
    drive_req(1, 32'h0, 32'd100, 32'd23, 7'h00, 4'd9);
    @(posedge clk); #1;
    req_valid_i = 2'b00;
    req_rs1_i[63:32] = 32'd999;
    @(negedge clk);
    n_checks++;
    if (alu_rs1_o === 32'd100) n_pass++;
    else $display("FAIL stable_rs1: got %0d, expected 100", alu_rs1_o);
    @(negedge clk);
    n_checks++;
    if (resp_valid_o === 2'b10 && resp_res_o === 32'd123) n_pass++;
    else $display("FAIL stable_res: got rv=%b res=%0d, expected 10 123", resp_valid_o, resp_res_o);
    wait_idle(ok);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL stable_idle: got busy=%b, expected 0", busy_o);
  endtask

  initial begin
    reset = 1'b1;
    req_valid_i = 2'b00; req_pc_i = '0; req_rs1_i = '0; req_rs2_i = '0;
    req_funct3_i = '0; req_funct7_i = '0; req_tag_i = '0; resp_ready_i = 2'b11;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    test_reset;
    test_contention;
    test_single_add;
    test_backpressure;
    test_wrong_owner;
    test_reset_mid_exec;
    test_operand_stability;
    n_checks++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL sb_leftover: got %0d pending, expected 0", sb.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
